// File: rtl/req_burst_gen_pkg.sv
// Shared types and defaults for the burst request front-end.
// Optional watchdog is enabled by defining REQ_TIMEOUT_EN.
package req_burst_pkg;

    localparam int DEF_LEN_W   = 4;
    localparam int DEF_GAP     = 2;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        BURST   = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_GAP_W = cnt_width(DEF_GAP);

endpackage

// File: rtl/req_burst_gen_if.sv
// Client job handshakes plus arbiter req/gnt for both channels.
// err_0/err_1 exist only when REQ_TIMEOUT_EN is defined.
interface req_burst_gen_if
    import req_burst_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
);
    logic             job_valid_0;
    logic [LEN_W-1:0] job_len_0;
    logic             job_ready_0;
    logic             job_valid_1;
    logic [LEN_W-1:0] job_len_1;
    logic             job_ready_1;
    logic             req_0;
    logic             req_1;
    logic             gnt_0;
    logic             gnt_1;
    logic             beat_0;
    logic             beat_1;
    logic             done_0;
    logic             done_1;
`ifdef REQ_TIMEOUT_EN
    logic             err_0;
    logic             err_1;
`endif

    modport master (
        output job_valid_0, job_len_0, job_valid_1, job_len_1, gnt_0, gnt_1,
        input  job_ready_0, job_ready_1, req_0, req_1,
        input  beat_0, beat_1, done_0, done_1
`ifdef REQ_TIMEOUT_EN
        , input err_0, err_1
`endif
    );

    modport slave (
        input  job_valid_0, job_len_0, job_valid_1, job_len_1, gnt_0, gnt_1,
        output job_ready_0, job_ready_1, req_0, req_1,
        output beat_0, beat_1, done_0, done_1
`ifdef REQ_TIMEOUT_EN
        , output err_0, err_1
`endif
    );

endinterface

// File: rtl/req_burst_gen_chan.sv
// One request channel: accepts a job, holds req until job_len+1 beats are granted,
// then keeps req low for GAP cycles. REQ_TIMEOUT_EN adds a no-grant watchdog.
module req_burst_chan
    import req_burst_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int GAP   = DEF_GAP
`ifdef REQ_TIMEOUT_EN
    , parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat,
    output logic             done
`ifdef REQ_TIMEOUT_EN
    , output logic           err
`endif
);

    localparam int               GAP_W    = cnt_width(GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

    state_t           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic             req_q;
    logic             last_beat;

    assign last_beat = (cnt_q == '0);
    assign job_ready = (state_q == IDLE) && !reset;
    assign req       = req_q;
    // Grants arriving in RELEASE are stale arbiter output and never count.
    assign beat      = ((state_q == REQ) || (state_q == BURST)) && gnt;
    assign done      = beat && last_beat;

`ifdef REQ_TIMEOUT_EN
    localparam int              WD_W    = cnt_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_q;
    logic            wd_hit;

    assign wd_hit = (state_q == REQ) && !gnt && (wd_q == WD_LAST);
    assign err    = wd_hit;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            req_q   <= 1'b0;
`ifdef REQ_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (job_valid) begin
                        cnt_q   <= job_len;
                        req_q   <= 1'b1;
                        state_q <= REQ;
`ifdef REQ_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end
                end
                REQ: begin
                    if (gnt) begin
                        if (last_beat) begin
                            state_q <= RELEASE;
                            req_q   <= 1'b0;
                            gap_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q - CNT_ONE;
                            state_q <= BURST;
                        end
                    end
`ifdef REQ_TIMEOUT_EN
                    if (gnt) begin
                        wd_q <= '0;
                    end else if (wd_hit) begin
                        state_q <= RELEASE;
                        req_q   <= 1'b0;
                        gap_q   <= '0;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_q + WD_ONE;
                    end
`endif
                end
                BURST: begin
                    if (gnt) begin
                        if (last_beat) begin
                            state_q <= RELEASE;
                            req_q   <= 1'b0;
                            gap_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/req_burst_gen.sv
// Two independent request channels feeding the two-client grant arbiter.
// REQ_TIMEOUT_EN enables the per-channel watchdog and the err_0/err_1 outputs.
module req_burst_gen
    import req_burst_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int GAP   = DEF_GAP
`ifdef REQ_TIMEOUT_EN
    , parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input logic             clock,
    input logic             reset,
    req_burst_gen_if.slave  bus
);

    logic [1:0]       job_valid;
    logic [LEN_W-1:0] job_len [2];
    logic [1:0]       job_ready;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [1:0]       beat;
    logic [1:0]       done;

    assign job_valid  = {bus.job_valid_1, bus.job_valid_0};
    assign job_len[0] = bus.job_len_0;
    assign job_len[1] = bus.job_len_1;
    assign gnt        = {bus.gnt_1, bus.gnt_0};

    assign bus.job_ready_0 = job_ready[0];
    assign bus.job_ready_1 = job_ready[1];
    assign bus.req_0       = req[0];
    assign bus.req_1       = req[1];
    assign bus.beat_0      = beat[0];
    assign bus.beat_1      = beat[1];
    assign bus.done_0      = done[0];
    assign bus.done_1      = done[1];

`ifdef REQ_TIMEOUT_EN
    logic [1:0] err;
    assign bus.err_0 = err[0];
    assign bus.err_1 = err[1];
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            req_burst_chan #(
                .LEN_W   (LEN_W),
                .GAP     (GAP)
`ifdef REQ_TIMEOUT_EN
                , .TIMEOUT (TIMEOUT)
`endif
            ) u_chan (
                .clock     (clock),
                .reset     (reset),
                .job_valid (job_valid[gi]),
                .job_len   (job_len[gi]),
                .job_ready (job_ready[gi]),
                .req       (req[gi]),
                .gnt       (gnt[gi]),
                .beat      (beat[gi]),
                .done      (done[gi])
`ifdef REQ_TIMEOUT_EN
                , .err     (err[gi])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_req_burst_gen.sv
// Directed-vector bench for req_burst_gen; each vector checks both channels'
// {job_ready, req, beat, done, err} after the inputs settle mid-cycle.
module tb_req_burst_gen;
    import req_burst_pkg::*;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;
    int   vidx;

    req_burst_gen_if #(.LEN_W(4)) bus ();

    req_burst_gen #(
        .LEN_W   (4),
        .GAP     (2)
`ifdef REQ_TIMEOUT_EN
        , .TIMEOUT (8)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic err_0_s;
    logic err_1_s;
`ifdef REQ_TIMEOUT_EN
    assign err_0_s = bus.err_0;
    assign err_1_s = bus.err_1;
`else
    assign err_0_s = 1'b0;
    assign err_1_s = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", tag, got[9:0], want[9:0]);
        end
    endtask

    function automatic logic [4:0] obs0();
        return {bus.job_ready_0, bus.req_0, bus.beat_0, bus.done_0, err_0_s};
    endfunction

    function automatic logic [4:0] obs1();
        return {bus.job_ready_1, bus.req_1, bus.beat_1, bus.done_1, err_1_s};
    endfunction

    // One clock of stimulus; expectations are {ready, req, beat, done, err}.
    task automatic vec(input string tag,
                       input logic v0, input logic [3:0] l0, input logic g0,
                       input logic v1, input logic [3:0] l1, input logic g1,
                       input logic [4:0] e0, input logic [4:0] e1);
        @(negedge clock);
        bus.job_valid_0 = v0;
        bus.job_len_0   = l0;
        bus.gnt_0       = g0;
        bus.job_valid_1 = v1;
        bus.job_len_1   = l1;
        bus.gnt_1       = g1;
        #1;
        chk($sformatf("%s.%0d/ch0", tag, vidx), 32'(obs0()), 32'(e0));
        chk($sformatf("%s.%0d/ch1", tag, vidx), 32'(obs1()), 32'(e1));
        vidx++;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vidx  = 0;
        reset = 1'b1;
        bus.job_valid_0 = 1'b0;
        bus.job_len_0   = '0;
        bus.gnt_0       = 1'b0;
        bus.job_valid_1 = 1'b0;
        bus.job_len_1   = '0;
        bus.gnt_1       = 1'b0;

        #3;
        chk("reset_hold", 32'({obs0(), obs1()}), 32'(0));
        @(negedge clock);
        reset = 1'b0;
        vec("reset_idle", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);

        // Single burst, len 3, grant follows req two cycles late.
        vec("burst", 1, 3, 0, 0, 0, 0, 5'b10000, 5'b10000);
        vec("burst", 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);
        vec("burst", 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);
        vec("burst", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b10000);
        vec("burst", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b10000);
        vec("burst", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b10000);
        vec("burst", 0, 0, 1, 0, 0, 0, 5'b01110, 5'b10000);
        vec("burst", 0, 0, 1, 0, 0, 0, 5'b00000, 5'b10000);
        vec("burst", 0, 0, 1, 0, 0, 0, 5'b00000, 5'b10000);
        vec("burst", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);

        // Single-beat job on channel 1 with grant already present.
        vec("single", 0, 0, 0, 1, 0, 1, 5'b10000, 5'b10000);
        vec("single", 0, 0, 0, 0, 0, 1, 5'b10000, 5'b01110);
        vec("single", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b00000);
        vec("single", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b00000);
        vec("single", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);

        // Contention: both len 2, arbiter serves channel 0 first.
        vec("contend", 1, 2, 0, 1, 2, 0, 5'b10000, 5'b10000);
        vec("contend", 0, 0, 0, 0, 0, 0, 5'b01000, 5'b01000);
        vec("contend", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b01000);
        vec("contend", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b01000);
        vec("contend", 0, 0, 1, 0, 0, 0, 5'b01110, 5'b01000);
        vec("contend", 0, 0, 1, 0, 0, 0, 5'b00000, 5'b01000);
        vec("contend", 0, 0, 0, 0, 0, 0, 5'b00000, 5'b01000);
        vec("contend", 0, 0, 0, 0, 0, 1, 5'b10000, 5'b01100);
        vec("contend", 0, 0, 0, 0, 0, 1, 5'b10000, 5'b01100);
        vec("contend", 0, 0, 0, 0, 0, 1, 5'b10000, 5'b01110);
        vec("contend", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b00000);
        vec("contend", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b00000);
        vec("contend", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);

        // Grant gaps: len 3 with gnt toggling 1,0,1,0,...
        vec("gaps", 1, 3, 0, 0, 0, 0, 5'b10000, 5'b10000);
        vec("gaps", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b10000);
        vec("gaps", 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);
        vec("gaps", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b10000);
        vec("gaps", 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);
        vec("gaps", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b10000);
        vec("gaps", 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);
        vec("gaps", 0, 0, 1, 0, 0, 0, 5'b01110, 5'b10000);
        vec("gaps", 0, 0, 0, 0, 0, 0, 5'b00000, 5'b10000);
        vec("gaps", 0, 0, 0, 0, 0, 0, 5'b00000, 5'b10000);
        vec("gaps", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);

        // Asynchronous reset after two beats of a len 5 burst.
        vec("rst_mid", 1, 5, 0, 0, 0, 0, 5'b10000, 5'b10000);
        vec("rst_mid", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b10000);
        vec("rst_mid", 0, 0, 1, 0, 0, 0, 5'b01100, 5'b10000);
        @(negedge clock);
        bus.gnt_0 = 1'b1;
        #1;
        chk("rst_mid_pre", 32'(obs0()), 32'(5'b01100));
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async", 32'({obs0(), obs1()}), 32'(0));
        @(negedge clock);
        chk("rst_held", 32'({obs0(), obs1()}), 32'(0));
        reset = 1'b0;
        vec("rst_after", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);

`ifdef REQ_TIMEOUT_EN
        // Watchdog: grant never arrives, err on the 8th REQ cycle.
        vec("timeout", 1, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);
        for (int i = 0; i < 7; i++) begin
            vec("timeout", 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);
        end
        vec("timeout", 0, 0, 0, 0, 0, 0, 5'b01001, 5'b10000);
        vec("timeout", 0, 0, 0, 0, 0, 0, 5'b00000, 5'b10000);
        vec("timeout", 0, 0, 0, 0, 0, 0, 5'b00000, 5'b10000);
        vec("timeout", 0, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/req_burst_gen.md
Name: req_burst_gen

Overview:
- Upstream request front-end for the two-client grant arbiter.
- Accepts burst jobs from two clients on a valid/ready handshake and drives the arbiter's req_0/req_1.
- Counts granted beats on gnt_0/gnt_1, then withdraws the request so the arbiter returns to IDLE.
- Built from one per-channel FSM instantiated twice; the channels are fully independent.

Parameters:
- LEN_W, 4, width of job length field; burst = job_len+1 beats (1..16 at default).
- GAP, 2, cycles req is held low after a burst; must be >= 2 to cover the arbiter's registered state-to-grant delay.
- TIMEOUT, 64, cycles of unanswered request before abort (only with optional feature).

Ports:
- clock        input   1      system clock, rising edge
- reset        input   1      asynchronous, active-high reset
- job_valid_0  input   1      client 0 job offer
- job_len_0    input   LEN_W  client 0 beats minus one
- job_ready_0  output  1      client 0 job accepted this cycle
- job_valid_1  input   1      client 1 job offer
- job_len_1    input   LEN_W  client 1 beats minus one
- job_ready_1  output  1      client 1 job accepted this cycle
- req_0        output  1      request to arbiter, channel 0
- req_1        output  1      request to arbiter, channel 1
- gnt_0        input   1      grant from arbiter, channel 0
- gnt_1        input   1      grant from arbiter, channel 1
- beat_0       output  1      pulse per granted beat, channel 0
- beat_1       output  1      pulse per granted beat, channel 1
- done_0       output  1      pulse on last beat, channel 0
- done_1       output  1      pulse on last beat, channel 1

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting reset forces every output to 0, every FSM to IDLE and every counter to 0 immediately, regardless of clock.
- Reset mid-burst abandons the job with no done pulse.
- Per-channel FSM states: IDLE, REQ, BURST, RELEASE.
- IDLE:
  - job_ready = 1 (combinational from state).
  - When job_valid && job_ready: latch cnt <= job_len, go to REQ.
- REQ:
  - req = 1 (registered), job_ready = 0.
  - First cycle with gnt = 1 counts as a beat: beat = 1 in the same cycle (combinational req-state && gnt).
  - If cnt == 0 in that cycle: done = 1 and go to RELEASE; otherwise decrement cnt and go to BURST.
- BURST:
  - req = 1.
  - Each cycle with gnt = 1: beat = 1 and cnt decrements.
  - Cycle where gnt = 1 and cnt == 0: done = 1, go to RELEASE.
  - gnt = 0 in BURST (preempted or not yet settled): no beat, cnt holds, remain in BURST.
- RELEASE:
  - req = 0, job_ready = 0.
  - Gap counter runs GAP cycles, then IDLE.
  - gnt seen high during RELEASE is ignored (no beat), since the arbiter's registered grant lags.
- Latency: job accept to req high = 1 cycle. Single-beat job (len 0) with grant present: req high 1 cycle after accept, done in that grant cycle.
- Back-to-back jobs: next job_ready no earlier than GAP+1 cycles after done.
- Simultaneous requests from both channels are legal; arbitration belongs to the arbiter.
- A channel waiting in REQ simply holds req until granted.
- cnt width is LEN_W. Decrement never wraps, because exit happens at 0.

Optional Feature:
- REQ_TIMEOUT_EN defined:
  - Per-channel watchdog counts consecutive cycles in REQ with gnt = 0.
  - On reaching TIMEOUT: drop req, go to RELEASE, pulse err_N (extra output ports err_0, err_1, reset 0) for 1 cycle; no done.
  - Counter clears on any grant.
- Not defined: no watchdog, no err ports; REQ waits indefinitely.

Decomposition:
- Package req_burst_pkg:
  - State encoding constants IDLE/REQ/BURST/RELEASE (one-hot, 4 bits).
  - Default LEN_W, GAP, TIMEOUT.
  - Gap-counter width derived as clog2(GAP+1).
- Sub-module req_burst_chan: one channel FSM plus counters, with ports job_valid/job_len/job_ready/req/gnt/beat/done(/err).
- Top req_burst_gen instantiates two copies and wires them to the _0/_1 ports.

Test Plan:
- Reset: assert reset asynchronously mid-BURST (len 5, 2 beats done) -> all outputs 0 immediately, no done, job_ready_0 = 1 after release.
- Single burst: job_len_0 = 3, gnt_0 tied to req_0 delayed 2 cycles -> exactly 4 beat_0 pulses, done_0 on the 4th, req_0 low for 2 cycles, then job_ready_0 = 1.
- Single-beat job: job_len_1 = 0 -> one beat_1 and done_1 in the same cycle, then RELEASE.
- Contention: both channels offer len 2 at once, arbiter model grants 0 first -> channel 1 holds req_1 through channel 0's burst plus gap, then completes 3 beats; no beats counted without grant.
- Grant gaps: gnt_0 toggles 1,0,1,0 during a len 3 burst -> beats only on gnt cycles, done_0 after the 4th grant cycle.
- REQ_TIMEOUT_EN with TIMEOUT = 8, gnt_0 stuck low -> err_0 pulse at cycle 8 of REQ, req_0 drops, no done_0.
